// File: rtl/blend_pkg.sv
// Shared defaults, FSM state type and alpha helper for the image blend stage.
package blend_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int NUM_CH_DEF = 3;
    localparam int ROUND_C    = 128;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Stretches 0..255 onto 0..256 so that 255 passes image A through untouched.
    function automatic logic [8:0] alpha_eff(input logic [7:0] alpha);
        return {1'b0, alpha} + {8'd0, alpha[7]};
    endfunction

endpackage

// File: rtl/blend_channel.sv
// One colour channel of the blend: register inputs, form both weighted products,
// then round and scale back to DATA_W bits. All stages advance on i_en.
module blend_channel
    import blend_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [8:0]        i_ae,
    output logic [DATA_W-1:0] o_pix
);

    localparam int SUM_W = DATA_W + 9;

    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [8:0]        r_ae;
    logic [SUM_W-1:0]  r_prodA;
    logic [SUM_W-1:0]  r_prodB;
    logic [DATA_W-1:0] r_pix;
    logic [SUM_W-1:0]  w_sum;

    // Weights sum to 256, so the rounded result can never exceed the channel maximum.
    assign w_sum = r_prodA + r_prodB + SUM_W'(ROUND_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_ae    <= '0;
            r_prodA <= '0;
            r_prodB <= '0;
            r_pix   <= '0;
        end else if (i_en) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_ae    <= i_ae;
            r_prodA <= SUM_W'(r_a) * SUM_W'(r_ae);
            r_prodB <= SUM_W'(r_b) * SUM_W'(9'd256 - r_ae);
            r_pix   <= DATA_W'(w_sum >> 8);
        end
    end

    assign o_pix = r_pix;

endmodule

// File: rtl/image_blend_stage.sv
// Alpha-blends two RGB streams with per-frame frozen image selects and weight.
// Define BLEND_FADE_EN to make the weight glide toward blend_factor frame by frame.
module image_blend_stage
    import blend_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int NUM_IMAGES = 16
`ifdef BLEND_FADE_EN
    ,
    parameter int FADE_STEP  = 4
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               image_index,
    input  logic [7:0]               blend_factor,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic                     s_sof,
    input  logic                     s_last,
    input  logic [DATA_W*NUM_CH-1:0] s_pix_a,
    input  logic [DATA_W*NUM_CH-1:0] s_pix_b,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W*NUM_CH-1:0] m_pix,
    output logic                     m_sof,
    output logic                     m_last,
    output logic [3:0]               img_sel_a,
    output logic [3:0]               img_sel_b,
    output logic                     sync_err
);

    localparam logic [31:0] NUM_IMG_U = NUM_IMAGES;

    state_t      r_state;
    state_t      w_stateNext;
    logic        w_en;
    logic        w_accept;
    logic        w_take;
    logic        w_follow;
    logic        w_errSet;
    logic [2:0]  r_valid;
    logic [2:0]  r_sof;
    logic [2:0]  r_last;
    logic [3:0]  r_selA;
    logic [3:0]  r_selB;
    logic        r_syncErr;
    logic [7:0]  r_alpha;
    logic [7:0]  w_alphaUse;
    logic [8:0]  w_ae;
    logic [31:0] w_idxWide;
    logic [3:0]  w_selA;
    logic [3:0]  w_selB;

    // A single global enable keeps every stage in lockstep, so a stall freezes m_*.
    assign w_en     = !r_valid[2] | m_ready;
    assign s_ready  = w_en;
    assign w_accept = s_valid & w_en;

    assign w_idxWide = {28'd0, image_index};
    assign w_selA    = 4'(w_idxWide % NUM_IMG_U);
    assign w_selB    = 4'((w_idxWide + 32'd1) % NUM_IMG_U);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // A one-beat frame (sof and last together) never leaves IDLE.
    always_comb begin
        w_stateNext = r_state;
        w_take      = 1'b0;
        w_follow    = 1'b0;
        w_errSet    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_accept) begin
                    w_follow = 1'b1;
                end else if (s_sof) begin
                    w_take = 1'b1;
                    if (!s_last) begin
                        w_stateNext = ACTIVE;
                    end
                end else begin
                    w_errSet = 1'b1;
                end
            end
            ACTIVE: begin
                if (w_accept) begin
                    w_take = 1'b1;
                    if (s_sof) begin
                        w_errSet = 1'b1;
                    end
                    if (s_last) begin
                        w_stateNext = IDLE;
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_selA    <= 4'd0;
            r_selB    <= 4'd1;
            r_syncErr <= 1'b0;
        end else begin
            if (w_follow) begin
                r_selA <= w_selA;
                r_selB <= w_selB;
            end
            if (w_errSet) begin
                r_syncErr <= 1'b1;
            end
        end
    end

`ifdef BLEND_FADE_EN
    localparam logic [7:0] STEP = 8'(FADE_STEP);

    logic [7:0] w_alphaStep;

    always_comb begin
        w_alphaStep = r_alpha;
        if (blend_factor > r_alpha) begin
            if (blend_factor - r_alpha > STEP) begin
                w_alphaStep = r_alpha + STEP;
            end else begin
                w_alphaStep = blend_factor;
            end
        end else if (blend_factor < r_alpha) begin
            if (r_alpha - blend_factor > STEP) begin
                w_alphaStep = r_alpha - STEP;
            end else begin
                w_alphaStep = blend_factor;
            end
        end
    end

    // The sof beat already blends with the stepped weight so the whole frame agrees.
    assign w_alphaUse = (r_state == IDLE) ? w_alphaStep : r_alpha;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alpha <= 8'd128;
        end else if (w_take && (r_state == IDLE)) begin
            r_alpha <= w_alphaStep;
        end
    end
`else
    assign w_alphaUse = r_alpha;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alpha <= 8'd128;
        end else if (w_follow) begin
            r_alpha <= blend_factor;
        end
    end
`endif

    assign w_ae = alpha_eff(w_alphaUse);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 3'd0;
            r_sof   <= 3'd0;
            r_last  <= 3'd0;
        end else if (w_en) begin
            r_valid <= {r_valid[1:0], w_take};
            r_sof   <= {r_sof[1:0], s_sof & w_take};
            r_last  <= {r_last[1:0], s_last & w_take};
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        blend_channel #(
            .DATA_W (DATA_W)
        ) u_channel (
            .clk   (clk),
            .rst   (rst),
            .i_en  (w_en),
            .i_a   (s_pix_a[c*DATA_W +: DATA_W]),
            .i_b   (s_pix_b[c*DATA_W +: DATA_W]),
            .i_ae  (w_ae),
            .o_pix (m_pix[c*DATA_W +: DATA_W])
        );
    end

    assign m_valid   = r_valid[2];
    assign m_sof     = r_sof[2];
    assign m_last    = r_last[2];
    assign img_sel_a = r_selA;
    assign img_sel_b = r_selB;
    assign sync_err  = r_syncErr;

endmodule

// File: doc/image_blend_stage.md
Name: image_blend_stage

Overview:
- Consumes image_index and blend_factor from the button/user-interaction block and alpha-blends two RGB pixel streams (image A, image B) into one output stream.
- Drives the frame-buffer image selects (img_sel_a/b), so the buffer fetches the right image pair.
- Freezes select and blend settings for a whole frame, so a button press never tears a frame mid-scan.
- 3-stage pipelined datapath with valid/ready handshakes; sits between the frame-buffer reader and the video output formatter.

Parameters:
- DATA_W, 8, bits per colour channel.
- NUM_CH, 3, channels per pixel (R,G,B; R in MSBs).
- NUM_IMAGES, 16, image count; img_sel wraps modulo this value.
- FADE_STEP, 4, maximum per-frame alpha change (fade feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- image_index  in  4  requested image A index
- blend_factor  in  8  requested weight of A (0 = all B, 255 = all A)
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid & s_ready
- s_sof  in  1  first pixel of frame
- s_last  in  1  last pixel of frame
- s_pix_a  in  DATA_W*NUM_CH  pixel from image A
- s_pix_b  in  DATA_W*NUM_CH  pixel from image B
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream ready
- m_pix  out  DATA_W*NUM_CH  blended pixel
- m_sof  out  1  delayed s_sof
- m_last  out  1  delayed s_last
- img_sel_a  out  4  image index for stream A
- img_sel_b  out  4  (img_sel_a+1) mod NUM_IMAGES
- sync_err  out  1  sticky framing-error flag

Behaviour:
- Reset values: state IDLE; m_valid=0; m_sof=0; m_last=0; m_pix=0; img_sel_a=0; img_sel_b=1; alpha_lat=128; sync_err=0.
- FSM IDLE:
  - Every cycle without an accepted beat: img_sel_a<=image_index, img_sel_b<=(image_index+1) mod NUM_IMAGES, alpha_lat<=blend_factor.
  - Accepted beat with s_sof=1 -> ACTIVE. This beat and the rest of the frame use the current alpha_lat.
  - Accepted beat with s_sof=0 is discarded (not pipelined) and sets sync_err.
- FSM ACTIVE:
  - img_sel_a/b and alpha_lat are frozen.
  - Accepted beat with s_last=1 -> IDLE, even if s_sof=1 on the same beat.
  - Accepted s_sof=1 beat in ACTIVE sets sync_err; it is processed normally and the latched params are kept.
- Handshake:
  - Pipeline enable en = !m_valid | m_ready; s_ready = en in both states.
  - All stages advance together on en; a stall holds m_* stable.
  - A beat accepted at cycle t appears on m_* at cycle t+3 with no stall.
  - Full throughput is 1 pixel/clock; no beat is lost or duplicated.
- Arithmetic, per channel:
  - ae = alpha_lat + alpha_lat[7], range 0..256.
  - out = (a*ae + b*(256-ae) + 128) >> 8, computed in 17 bits.
  - ae=256 gives a exactly; ae=0 gives b exactly; the result never exceeds 2^DATA_W-1.
  - Stage 1 registers pixels and ae; stage 2 registers the two products; stage 3 registers the rounded sum.
- Image select: image_index >= NUM_IMAGES is reduced modulo NUM_IMAGES. image_index=15 gives img_sel_b=0.
- sync_err is cleared only by rst.
- rst mid-frame: pipeline is flushed (m_valid=0 asynchronously) and the FSM returns to IDLE.

Optional Feature:
- BLEND_FADE_EN defined:
  - alpha_cur steps toward blend_factor by at most FADE_STEP, once per accepted sof beat in IDLE.
  - The blend uses alpha_cur, which gives a smooth cross-fade over several frames.
  - Reset alpha_cur=128.
- BLEND_FADE_EN undefined: alpha_lat follows blend_factor directly, as described under Behaviour.
- img_sel behaviour is identical in both builds.

Decomposition:
- Package blend_pkg holds:
  - DATA_W and NUM_CH defaults.
  - The state enum {IDLE, ACTIVE}.
  - Function alpha_eff(8b) -> 9b.
  - Rounding constant 128.
- Sub-module blend_channel: one channel's 3-stage multiply/add/round pipeline with enable input. It is instantiated NUM_CH times.
- The FSM, handshake and sideband pipeline stay in the top module.

Test Plan:
- blend_factor=255; one-beat frame with a=0x112233, b=0xFFFFFF -> m_pix=0x112233 exactly 3 cycles after acceptance, with m_sof=m_last=1.
- blend_factor=0 -> m_pix=b. blend_factor=128 with a=0xFF0000, b=0x000000 -> m_pix=0x800000.
- image_index changes 3->4 mid-frame -> img_sel_a/b stay 3/4 until the s_last beat, then become 4/5. image_index=15 in IDLE -> img_sel_b=0.
- m_ready low for 5 cycles mid-frame -> s_ready low and m_pix held stable; after release, all 16 pixels are output in order with none missing.
- Non-sof beat in IDLE -> dropped, sync_err=1. rst asserted mid-frame -> m_valid=0, img_sel_a=0, state IDLE.
- BLEND_FADE_EN: blend_factor jumps from 128 to 255 -> alpha_cur reads 132, 136, ... on successive frames and reaches 255 after 32 frames.
